axis_grant_mux: RTL

//  Downstream consumer of the arbiter: an N-port AXI-Stream frame multiplexer. Drives the arbiter's

---
 rtl/axis_grant_mux.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/axis_grant_mux.sv
// -----------------------------------------------------------------------------
// axis_grant_mux
//   N-port AXI-Stream frame multiplexer that sits downstream of a blocking,
//   acknowledge-released arbiter. Each port requests while it has data. The
//   arbiter's registered grant picks the input. The granted frame is forwarded
//   whole through a two-entry output stage (output register plus skid
//   register). This gives one cycle of latency at full throughput. The last
//   beat of a frame pulses arb_acknowledge so the arbiter can re-arbitrate.
//
//   Optional feature macro: AXIS_GRANT_MUX_TID_EN
//     When defined, adds m_axis_tid, which carries the source port index with
//     every beat.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   s_axis_*            PORTS packed input streams (port i in slice i)
//   m_axis_*            merged output stream (m_axis_tid only with the macro)
//   arb_request         per-port request to the arbiter
//   arb_acknowledge     per-port last-beat acknowledge to the arbiter
//   arb_grant           one-hot grant from the arbiter
//   arb_grant_valid     grant qualifier from the arbiter
//   arb_grant_encoded   binary grant index; selects the input payload
// -----------------------------------------------------------------------------
module axis_grant_mux #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [PORTS-1:0]              s_axis_tlast,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  output logic [PORTS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
`ifdef AXIS_GRANT_MUX_TID_EN
  output logic [$clog2(PORTS)-1:0]      m_axis_tid,
`endif
  input  logic                          m_axis_tready,
  output logic [PORTS-1:0]              arb_request,
  output logic [PORTS-1:0]              arb_acknowledge,
  input  logic [PORTS-1:0]              arb_grant,
  input  logic                          arb_grant_valid,
  input  logic [$clog2(PORTS)-1:0]      arb_grant_encoded
);

  localparam int SEL_W = $clog2(PORTS);

  typedef struct packed {
`ifdef AXIS_GRANT_MUX_TID_EN
    logic [SEL_W-1:0]      id;
`endif
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic [USER_WIDTH-1:0] user;
    logic                  last;
  } beat_t;

  logic             ready_reg, ready_next;
  logic             out_valid, out_valid_next;
  logic             skid_valid, skid_valid_next;
  logic             load_out_in, load_out_skid, load_skid;
  beat_t            in_beat, out_beat, skid_beat;
  logic [PORTS-1:0] accept;
  logic             accept_any;

  // Only the granted port sees ready, and only while the output stage can
  // take a beat.
  assign s_axis_tready   = arb_grant & {PORTS{arb_grant_valid & ready_reg}};
  assign accept          = s_axis_tvalid & s_axis_tready;
  assign accept_any      = |accept;
  assign arb_acknowledge = accept & s_axis_tlast;
  // Drop the request during the acknowledge cycle. This lets the arbiter
  // re-arbitrate instead of re-granting the port that just finished.
  assign arb_request     = s_axis_tvalid & (~arb_grant | ~arb_acknowledge);

  // Payload select by encoded grant.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    in_beat = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (arb_grant_encoded == SEL_W'(i)) begin
        in_beat.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        in_beat.keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        in_beat.user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        in_beat.last = s_axis_tlast[i];
      end
    end
`ifdef AXIS_GRANT_MUX_TID_EN
    in_beat.id = arb_grant_encoded;
`endif
  end

  // Output stage steering. While ready_reg is high the skid is empty. An
  // incoming beat goes straight to the output when the output is empty or
  // draining, and to the skid otherwise. While ready_reg is low no beat is
  // accepted; the skid refills the output as the output drains.
  always_comb begin
    out_valid_next  = out_valid;
    skid_valid_next = skid_valid;
    load_out_in     = 1'b0;
    load_out_skid   = 1'b0;
    load_skid       = 1'b0;
    if (ready_reg) begin
      if (m_axis_tready || !out_valid) begin
        out_valid_next = accept_any;
        load_out_in    = accept_any;
      end else begin
        skid_valid_next = accept_any;
        load_skid       = accept_any;
      end
    end else if (m_axis_tready) begin
      out_valid_next  = skid_valid;
      skid_valid_next = 1'b0;
      load_out_skid   = skid_valid;
    end
  end

  // Registered ready stays high only if next cycle's beat is guaranteed a
  // slot: either the downstream drains, or the skid is free and will
  // remain free.
  assign ready_next = m_axis_tready | (~skid_valid & (~out_valid | ~accept_any));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg  <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_beat   <= '0;
      skid_beat  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, so statement order inside this block is irrelevant.
      ready_reg  <= ready_next;
      out_valid  <= out_valid_next;
      skid_valid <= skid_valid_next;
      if (load_out_in) begin
        out_beat <= in_beat;
      end else if (load_out_skid) begin
        out_beat <= skid_beat;
      end
      if (load_skid) begin
        skid_beat <= in_beat;
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tuser  = out_beat.user;
  assign m_axis_tlast  = out_beat.last;
`ifdef AXIS_GRANT_MUX_TID_EN
  assign m_axis_tid    = out_beat.id;
`endif

endmodule
